// File: rtl/branch_target_buffer_pkg.sv
// Shared fetch-unit types for the branch target buffer.
// Optional feature macro: BTB_TWO_BIT_COUNTER_EN (2-bit direction counters).
package FetchUnitTypes;

  localparam int BTB_ENTRY_NUM   = 64;
  localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
  localparam int BTB_TAG_WIDTH   = 30 - BTB_INDEX_WIDTH;

  typedef logic [BTB_INDEX_WIDTH-1:0] BtbIndex;
  typedef logic [BTB_TAG_WIDTH-1:0]   BtbTag;

  typedef enum logic [1:0] {
    StronglyNotTaken = 2'b00,
    WeaklyNotTaken   = 2'b01,
    WeaklyTaken      = 2'b10,
    StronglyTaken    = 2'b11
  } BtbCounter;

  typedef struct packed {
    logic        valid;
    BtbTag       tag;
    logic [31:0] target;
`ifdef BTB_TWO_BIT_COUNTER_EN
    BtbCounter   counter;
`endif
  } BtbEntry;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } BranchPredict;

`ifdef BTB_TWO_BIT_COUNTER_EN
  function automatic BtbCounter NextBtbCounter(
    input BtbCounter cur,
    input logic      taken
  );
    BtbCounter nxt;
    nxt = cur;
    if (taken && cur != StronglyTaken)
      nxt = BtbCounter'(cur + 2'd1);
    else if (!taken && cur != StronglyNotTaken)
      nxt = BtbCounter'(cur - 2'd1);
    return nxt;
  endfunction
`endif

endpackage

// File: rtl/branch_target_buffer_if.sv
// Memory-access stage resolution bundle feeding the BTB update port.
// BTB modport is the consumer view; master/slave are generic producer/consumer.
interface MemoryAccessStageIF;
  logic        valid;
  logic [31:0] pc;
  logic        isBranch;
  logic        isBranchTaken;
  logic [31:0] irregPc;

  modport master (
    output valid, pc, isBranch,
    output isBranchTaken, irregPc
  );

  modport slave (
    input valid, pc, isBranch,
    input isBranchTaken, irregPc
  );

  modport BTB (
    input valid, pc, isBranch,
    input isBranchTaken, irregPc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational lookup, rising-edge update.
// BTB_TWO_BIT_COUNTER_EN adds per-entry 2-bit direction counters.
module branch_target_buffer
  import FetchUnitTypes::*;
#(
  parameter int ENTRY_NUM = BTB_ENTRY_NUM
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic        predictHit,
  output logic        predictTaken,
  output logic [31:0] predictTarget,
  MemoryAccessStageIF.BTB upd
);

  localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
  localparam int TAG_WIDTH   = 30 - INDEX_WIDTH;

  logic [ENTRY_NUM-1:0] r_valid;
  logic [TAG_WIDTH-1:0] r_tag    [ENTRY_NUM];
  logic [31:0]          r_target [ENTRY_NUM];
`ifdef BTB_TWO_BIT_COUNTER_EN
  BtbCounter            r_cnt    [ENTRY_NUM];
`endif

  logic [INDEX_WIDTH-1:0] w_fIdx;
  logic [TAG_WIDTH-1:0]   w_fTag;
  logic                   w_fHit;
  logic [INDEX_WIDTH-1:0] w_uIdx;
  logic [TAG_WIDTH-1:0]   w_uTag;
  logic                   w_uHit;
  logic                   w_updEn;
  logic                   w_alloc;
  logic                   w_tgtWr;

  assign w_fIdx = fetchPc[INDEX_WIDTH+1:2];
  assign w_fTag = fetchPc[31:INDEX_WIDTH+2];
  assign w_fHit = r_valid[w_fIdx]
               && (r_tag[w_fIdx] == w_fTag);

  assign predictHit    = w_fHit;
  assign predictTarget = w_fHit ? r_target[w_fIdx]
                                : 32'h0;
`ifdef BTB_TWO_BIT_COUNTER_EN
  assign predictTaken  = w_fHit & r_cnt[w_fIdx][1];
`else
  assign predictTaken  = w_fHit;
`endif

  assign w_uIdx  = upd.pc[INDEX_WIDTH+1:2];
  assign w_uTag  = upd.pc[31:INDEX_WIDTH+2];
  assign w_uHit  = r_valid[w_uIdx]
                && (r_tag[w_uIdx] == w_uTag);
  assign w_updEn = upd.valid & upd.isBranch;
  assign w_alloc = w_updEn & ~w_uHit
                 & upd.isBranchTaken;
  assign w_tgtWr = w_updEn & upd.isBranchTaken
                 & (w_uHit | w_alloc);

  // Tag/target are left out of the reset branch on purpose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
`ifdef BTB_TWO_BIT_COUNTER_EN
      for (int i = 0; i < ENTRY_NUM; i++)
        r_cnt[i] <= WeaklyNotTaken;
`endif
    end else begin
      if (w_alloc) begin
        r_valid[w_uIdx] <= 1'b1;
        r_tag[w_uIdx]   <= w_uTag;
      end
      if (w_tgtWr)
        r_target[w_uIdx] <= upd.irregPc;
`ifdef BTB_TWO_BIT_COUNTER_EN
      if (w_alloc)
        r_cnt[w_uIdx] <= WeaklyTaken;
      else if (w_updEn && w_uHit)
        r_cnt[w_uIdx] <= NextBtbCounter(
          r_cnt[w_uIdx], upd.isBranchTaken);
`else
      if (w_updEn && w_uHit && !upd.isBranchTaken)
        r_valid[w_uIdx] <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (ENTRY_NUM=64).
// Expectations cover both BTB_TWO_BIT_COUNTER_EN builds.
module tb_branch_target_buffer;
  import FetchUnitTypes::*;

`ifdef BTB_TWO_BIT_COUNTER_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [33:0] MISS = 34'h0;

  logic        clk;
  logic        rst;
  logic [31:0] fetchPc;
  logic        predictHit;
  logic        predictTaken;
  logic [31:0] predictTarget;

  MemoryAccessStageIF upd_if();

  branch_target_buffer #(.ENTRY_NUM(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetchPc       (fetchPc),
    .predictHit    (predictHit),
    .predictTaken  (predictTaken),
    .predictTarget (predictTarget),
    .upd           (upd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] sb_q[$];

  function automatic logic [33:0] pv(
    input logic h, input logic t,
    input logic [31:0] g);
    return {h, t, g};
  endfunction

  task automatic chk(input string tag,
    input logic [33:0] obs,
    input logic [33:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
        tag, obs[33], obs[32], obs[31:0],
        exp[33], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [33:0] obs_now();
    return {predictHit, predictTaken, predictTarget};
  endfunction

  task automatic pop_chk(input string tag);
    logic [33:0] e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk(tag, obs_now(), e);
    end
  endtask

  task automatic cyc(input string tag,
    input logic [31:0] fpc,
    input logic uv, input logic ub,
    input logic ut,
    input logic [31:0] upc,
    input logic [31:0] utgt,
    input logic [33:0] exp);
    fetchPc              = fpc;
    upd_if.valid         = uv;
    upd_if.isBranch      = ub;
    upd_if.isBranchTaken = ut;
    upd_if.pc            = upc;
    upd_if.irregPc       = utgt;
    sb_q.push_back(exp);
    @(negedge clk);
    pop_chk(tag);
    @(posedge clk);
    #1;
    upd_if.valid    = 1'b0;
    upd_if.isBranch = 1'b0;
  endtask

  task automatic look(input string tag,
    input logic [31:0] fpc,
    input logic [33:0] exp);
    cyc(tag, fpc, 1'b0, 1'b0, 1'b0,
        32'h0, 32'h0, exp);
  endtask

  task automatic now(input string tag,
    input logic [31:0] fpc,
    input logic [33:0] exp);
    fetchPc = fpc;
    sb_q.push_back(exp);
    #1;
    pop_chk(tag);
  endtask

  initial begin
    rst                  = 1'b1;
    fetchPc              = 32'h100;
    upd_if.valid         = 1'b0;
    upd_if.isBranch      = 1'b0;
    upd_if.isBranchTaken = 1'b0;
    upd_if.pc            = 32'h0;
    upd_if.irregPc       = 32'h0;
    sb_q.push_back(MISS);
    #1;
    pop_chk("rst_lookup");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    look("post_rst", 32'h100, MISS);
    cyc("alloc_same", 32'h100, 1, 1, 1,
        32'h100, 32'h200, MISS);
    cyc("hit_wt", 32'h100, 1, 1, 0,
        32'h100, 32'h0, pv(1, 1, 32'h200));
    cyc("nt1", 32'h100, 1, 1, 0,
        32'h100, 32'h0,
        EN ? pv(1, 0, 32'h200) : MISS);
    cyc("nt2", 32'h100, 1, 1, 1,
        32'h100, 32'h204,
        EN ? pv(1, 0, 32'h200) : MISS);
    cyc("t1", 32'h100, 1, 1, 1,
        32'h100, 32'h204,
        EN ? pv(1, 0, 32'h204)
           : pv(1, 1, 32'h204));
    cyc("t2", 32'h100, 1, 1, 1,
        32'h100, 32'h204, pv(1, 1, 32'h204));
    cyc("t3", 32'h100, 1, 1, 0,
        32'h100, 32'h0, pv(1, 1, 32'h204));
    look("sat", 32'h100,
         EN ? pv(1, 1, 32'h204) : MISS);

    cyc("alias_alloc", 32'h200, 1, 1, 1,
        32'h200, 32'h280, MISS);
    look("alias_old", 32'h100, MISS);
    cyc("nobranch", 32'h200, 1, 0, 1,
        32'h200, 32'hDEAD0, pv(1, 1, 32'h280));
    cyc("novalid", 32'h202, 0, 1, 1,
        32'h200, 32'hBEEF0, pv(1, 1, 32'h280));
    cyc("miss_nt", 32'h200, 1, 1, 0,
        32'h400, 32'h0, pv(1, 1, 32'h280));
    look("no_alloc", 32'h400, MISS);
    look("alias_new", 32'h200, pv(1, 1, 32'h280));

    cyc("bypass_none", 32'h300, 1, 1, 1,
        32'h300, 32'h340, MISS);
    look("after_upd", 32'h300, pv(1, 1, 32'h340));
    look("evicted", 32'h200, MISS);

    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("alloc%0d", i),
          32'h1004 + 32'(i * 4), 1, 1, 1,
          32'h1004 + 32'(i * 4),
          32'h2000 + 32'(i * 8), MISS);
    end
    look("alloc_hit", 32'h1010, pv(1, 1, 32'h2018));

    fetchPc = 32'h1004;
    #2;
    rst = 1'b1;
    now("arst_a", 32'h1004, MISS);
    now("arst_b", 32'h1010, MISS);
    now("arst_c", 32'h1028, MISS);
    now("arst_d", 32'h300, MISS);
    upd_if.valid         = 1'b1;
    upd_if.isBranch      = 1'b1;
    upd_if.isBranchTaken = 1'b1;
    upd_if.pc            = 32'h1004;
    upd_if.irregPc       = 32'h9990;
    @(posedge clk);
    #1;
    upd_if.valid    = 1'b0;
    upd_if.isBranch = 1'b0;
    rst = 1'b0;
    look("rst_discard", 32'h1004, MISS);
    look("rst_clear", 32'h1008, MISS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
